// File: rtl/mem_bus_arbiter_pkg.sv
// Shared bus encodings and owner typedef for the memory bus arbiter slice.
// XLEN defaults to 32 unless the build defines it.
`ifndef XLEN
`define XLEN 32
`endif

package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } bus_command_e;

  typedef enum logic [1:0] {
    BYTE   = 2'h0,
    HALF   = 2'h1,
    WORD   = 2'h2,
    DOUBLE = 2'h3
  } mem_size_e;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } owner_e;

  localparam int NUM_TAGS = 16;

endpackage

// File: rtl/mem_tag_owner_table.sv
// Per-tag ownership record for in-flight loads: valid bit plus requester.
// A set and a clear of the same tag in one cycle leaves the entry set.
module mem_tag_owner_table
  import mem_bus_arbiter_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       set_en,
  input  logic [3:0] set_tag,
  input  owner_e     set_owner,
  input  logic       clr_en,
  input  logic [3:0] clr_tag,
  input  logic [3:0] rd_tag,
  output logic       rd_valid,
  output owner_e     rd_owner
);

  logic [NUM_TAGS-1:0] valid_q, valid_d;
  logic [NUM_TAGS-1:0] owner_q, owner_d;

  always_comb begin
    valid_d = valid_q;
    owner_d = owner_q;
    if (clr_en) begin
      valid_d[clr_tag] = 1'b0;
    end
    if (set_en) begin
      valid_d[set_tag] = 1'b1;
      owner_d[set_tag] = set_owner;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
      owner_q <= '0;
    end else begin
      valid_q <= valid_d;
      owner_q <= owner_d;
    end
  end

  assign rd_valid = valid_q[rd_tag];
  assign rd_owner = owner_e'(owner_q[rd_tag]);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-requester memory bus arbiter: D-cache priority with I-cache starvation
// guard, load-count throttling, and tag-based routing of returned data.
`ifndef XLEN
`define XLEN 32
`endif

module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT    = 4,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        ic2arb_command,
  input  logic [`XLEN-1:0]  ic2arb_addr,
  input  logic [1:0]        dc2arb_command,
  input  logic [`XLEN-1:0]  dc2arb_addr,
  input  logic [63:0]       dc2arb_data,
  input  logic [1:0]        dc2arb_size,
  output logic [3:0]        arb2ic_response,
  output logic [63:0]       arb2ic_data,
  output logic [3:0]        arb2ic_tag,
  output logic [3:0]        arb2dc_response,
  output logic [63:0]       arb2dc_data,
  output logic [3:0]        arb2dc_tag,
  output logic [1:0]        proc2mem_command,
  output logic [`XLEN-1:0]  proc2mem_addr,
  output logic [63:0]       proc2mem_data,
  output logic [1:0]        proc2mem_size,
  input  logic [3:0]        mem2proc_response,
  input  logic [63:0]       mem2proc_data,
  input  logic [3:0]        mem2proc_tag,
  output logic [3:0]        outstanding,
  output logic              orphan_tag
);

  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] starve_cnt_q, starve_cnt_d;
  logic [3:0]    outstanding_q, outstanding_d;

  logic   ic_ok, dc_ok, starved, not_full;
  logic   grant_i, grant_d, accepted, alloc;
  logic   rd_valid, ret_valid;
  owner_e rd_owner;

  // A load is only eligible while the in-flight budget has room; stores always are.
  always_comb begin
    not_full = outstanding_q < 4'(MAX_OUTSTANDING);
    starved  = starve_cnt_q == SW'(STARVE_LIMIT);
    ic_ok    = (ic2arb_command != BUS_NONE) && (ic2arb_command != BUS_LOAD || not_full);
    dc_ok    = (dc2arb_command != BUS_NONE) && (dc2arb_command != BUS_LOAD || not_full);
    grant_i  = !reset && ic_ok && (!dc_ok || starved);
    grant_d  = !reset && dc_ok && !grant_i;
    accepted = mem2proc_response != 4'h0;

    proc2mem_command = BUS_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    proc2mem_size    = '0;
    if (grant_d) begin
      proc2mem_command = dc2arb_command;
      proc2mem_addr    = dc2arb_addr;
      proc2mem_data    = dc2arb_data;
      proc2mem_size    = dc2arb_size;
    end else if (grant_i) begin
      proc2mem_command = ic2arb_command;
      proc2mem_addr    = ic2arb_addr;
      proc2mem_size    = DOUBLE;
    end

    arb2ic_response = grant_i ? mem2proc_response : 4'h0;
    arb2dc_response = grant_d ? mem2proc_response : 4'h0;
    alloc = (grant_i || grant_d) && accepted && (proc2mem_command == BUS_LOAD);
  end

  mem_tag_owner_table u_owner_table (
    .clock     (clock),
    .reset     (reset),
    .set_en    (alloc),
    .set_tag   (mem2proc_response),
    .set_owner (grant_i ? OWNER_I : OWNER_D),
    .clr_en    (ret_valid),
    .clr_tag   (mem2proc_tag),
    .rd_tag    (mem2proc_tag),
    .rd_valid  (rd_valid),
    .rd_owner  (rd_owner)
  );

  always_comb begin
    ret_valid   = !reset && (mem2proc_tag != 4'h0) && rd_valid;
    orphan_tag  = !reset && (mem2proc_tag != 4'h0) && !rd_valid;
    arb2ic_tag  = (ret_valid && rd_owner == OWNER_I) ? mem2proc_tag : 4'h0;
    arb2dc_tag  = (ret_valid && rd_owner == OWNER_D) ? mem2proc_tag : 4'h0;
    arb2ic_data = (arb2ic_tag != 4'h0) ? mem2proc_data : 64'h0;
    arb2dc_data = (arb2dc_tag != 4'h0) ? mem2proc_data : 64'h0;
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (ic2arb_command == BUS_NONE || (grant_i && accepted)) begin
      starve_cnt_d = '0;
    end else if (!starved) begin
      starve_cnt_d = starve_cnt_q + SW'(1);
    end

    outstanding_d = outstanding_q;
    if (alloc && !ret_valid && outstanding_q != 4'hf) begin
      outstanding_d = outstanding_q + 4'h1;
    end else if (ret_valid && !alloc && outstanding_q != 4'h0) begin
      outstanding_d = outstanding_q - 4'h1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt_q  <= '0;
      outstanding_q <= '0;
    end else begin
      starve_cnt_q  <= starve_cnt_d;
      outstanding_q <= outstanding_d;
    end
  end

  assign outstanding = outstanding_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: arbitration, starvation, throttling,
// tag routing, orphan returns and reset behaviour with default parameters.
`ifndef XLEN
`define XLEN 32
`endif

module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  logic              clock = 1'b0;
  logic              reset;
  logic [1:0]        ic2arb_command;
  logic [`XLEN-1:0]  ic2arb_addr;
  logic [1:0]        dc2arb_command;
  logic [`XLEN-1:0]  dc2arb_addr;
  logic [63:0]       dc2arb_data;
  logic [1:0]        dc2arb_size;
  logic [3:0]        arb2ic_response, arb2ic_tag, arb2dc_response, arb2dc_tag;
  logic [63:0]       arb2ic_data, arb2dc_data;
  logic [1:0]        proc2mem_command, proc2mem_size;
  logic [`XLEN-1:0]  proc2mem_addr;
  logic [63:0]       proc2mem_data;
  logic [3:0]        mem2proc_response, mem2proc_tag;
  logic [63:0]       mem2proc_data;
  logic [3:0]        outstanding;
  logic              orphan_tag;

  int checks = 0;
  int errors = 0;

  mem_bus_arbiter dut (
    .clock             (clock),
    .reset             (reset),
    .ic2arb_command    (ic2arb_command),
    .ic2arb_addr       (ic2arb_addr),
    .dc2arb_command    (dc2arb_command),
    .dc2arb_addr       (dc2arb_addr),
    .dc2arb_data       (dc2arb_data),
    .dc2arb_size       (dc2arb_size),
    .arb2ic_response   (arb2ic_response),
    .arb2ic_data       (arb2ic_data),
    .arb2ic_tag        (arb2ic_tag),
    .arb2dc_response   (arb2dc_response),
    .arb2dc_data       (arb2dc_data),
    .arb2dc_tag        (arb2dc_tag),
    .proc2mem_command  (proc2mem_command),
    .proc2mem_addr     (proc2mem_addr),
    .proc2mem_data     (proc2mem_data),
    .proc2mem_size     (proc2mem_size),
    .mem2proc_response (mem2proc_response),
    .mem2proc_data     (mem2proc_data),
    .mem2proc_tag      (mem2proc_tag),
    .outstanding       (outstanding),
    .orphan_tag        (orphan_tag)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; the caller waits #1 before checking.
  task automatic cyc();
    @(negedge clock);
    ic2arb_command    = BUS_NONE;
    ic2arb_addr       = '0;
    dc2arb_command    = BUS_NONE;
    dc2arb_addr       = '0;
    dc2arb_data       = '0;
    dc2arb_size       = '0;
    mem2proc_response = '0;
    mem2proc_data     = '0;
    mem2proc_tag      = '0;
  endtask

  logic [63:0] d;
  logic [`XLEN-1:0] a;

  initial begin
    reset = 1'b1;
    cyc();
    ic2arb_command = BUS_LOAD;
    dc2arb_command = BUS_LOAD;
    mem2proc_response = 4'd3;
    mem2proc_tag = 4'd5;
    #1;
    chk("rst_cmd", 64'(proc2mem_command), 64'(BUS_NONE));
    chk("rst_dc_resp", 64'(arb2dc_response), 64'h0);
    chk("rst_ic_resp", 64'(arb2ic_response), 64'h0);
    chk("rst_orphan", 64'(orphan_tag), 64'h0);
    cyc();
    #1;
    chk("rst_outstanding", 64'(outstanding), 64'h0);
    reset = 1'b0;

    // Both load: D wins, then tag 3 routes back to D.
    cyc();
    ic2arb_command = BUS_LOAD; ic2arb_addr = 'h100;
    dc2arb_command = BUS_LOAD; dc2arb_addr = 'h200;
    mem2proc_response = 4'd3;
    #1;
    chk("both_cmd", 64'(proc2mem_command), 64'(BUS_LOAD));
    chk("both_addr", 64'(proc2mem_addr), 64'h200);
    chk("both_dc_resp", 64'(arb2dc_response), 64'h3);
    chk("both_ic_resp", 64'(arb2ic_response), 64'h0);
    cyc();
    #1;
    chk("both_outstanding", 64'(outstanding), 64'h1);
    chk("idle_cmd", 64'(proc2mem_command), 64'(BUS_NONE));
    cyc();
    d = {$urandom, $urandom};
    mem2proc_tag = 4'd3; mem2proc_data = d;
    #1;
    chk("ret3_dc_tag", 64'(arb2dc_tag), 64'h3);
    chk("ret3_dc_data", arb2dc_data, d);
    chk("ret3_ic_tag", 64'(arb2ic_tag), 64'h0);
    chk("ret3_ic_data", arb2ic_data, 64'h0);
    chk("ret3_orphan", 64'(orphan_tag), 64'h0);
    cyc();
    #1;
    chk("ret3_outstanding", 64'(outstanding), 64'h0);

    // Starvation: I loses four times, wins the fifth, then loses again.
    for (int k = 1; k <= 6; k++) begin
      cyc();
      ic2arb_command = BUS_LOAD; ic2arb_addr = 'h1000 + k;
      dc2arb_command = BUS_LOAD; dc2arb_addr = 'h2000 + k;
      mem2proc_response = 4'(k);
      #1;
      if (k == 5) begin
        chk($sformatf("starve%0d_ic_resp", k), 64'(arb2ic_response), 64'(k));
        chk($sformatf("starve%0d_dc_resp", k), 64'(arb2dc_response), 64'h0);
        chk($sformatf("starve%0d_addr", k), 64'(proc2mem_addr), 64'h1000 + k);
      end else begin
        chk($sformatf("starve%0d_dc_resp", k), 64'(arb2dc_response), 64'(k));
        chk($sformatf("starve%0d_ic_resp", k), 64'(arb2ic_response), 64'h0);
        chk($sformatf("starve%0d_addr", k), 64'(proc2mem_addr), 64'h2000 + k);
      end
    end
    cyc();
    #1;
    chk("starve_outstanding", 64'(outstanding), 64'h6);
    for (int k = 1; k <= 6; k++) begin
      cyc();
      d = {$urandom, $urandom};
      mem2proc_tag = 4'(k); mem2proc_data = d;
      #1;
      if (k == 5) begin
        chk("drain_ic_tag", 64'(arb2ic_tag), 64'h5);
        chk("drain_ic_data", arb2ic_data, d);
        chk("drain_dc_tag5", 64'(arb2dc_tag), 64'h0);
      end else begin
        chk($sformatf("drain_dc_tag%0d", k), 64'(arb2dc_tag), 64'(k));
        chk($sformatf("drain_ic_tag%0d", k), 64'(arb2ic_tag), 64'h0);
      end
    end
    cyc();
    #1;
    chk("drain_outstanding", 64'(outstanding), 64'h0);

    // Fill to the in-flight limit with D loads on tags 1..8.
    for (int k = 1; k <= 8; k++) begin
      cyc();
      dc2arb_command = BUS_LOAD; dc2arb_addr = 'h3000 + k;
      mem2proc_response = 4'(k);
      #1;
    end
    cyc();
    #1;
    chk("full_outstanding", 64'(outstanding), 64'h8);
    cyc();
    dc2arb_command = BUS_LOAD; dc2arb_addr = 'h3100;
    mem2proc_response = 4'd9;
    #1;
    chk("full_load_cmd", 64'(proc2mem_command), 64'(BUS_NONE));
    chk("full_load_resp", 64'(arb2dc_response), 64'h0);
    cyc();
    d = {$urandom, $urandom};
    a = $urandom_range(32'h4000, 32'h4fff);
    ic2arb_command = BUS_LOAD; ic2arb_addr = 'h5000;
    dc2arb_command = BUS_STORE; dc2arb_addr = a; dc2arb_data = d; dc2arb_size = 2'd2;
    mem2proc_response = 4'd9;
    #1;
    chk("full_store_cmd", 64'(proc2mem_command), 64'(BUS_STORE));
    chk("full_store_addr", 64'(proc2mem_addr), 64'(a));
    chk("full_store_data", proc2mem_data, d);
    chk("full_store_size", 64'(proc2mem_size), 64'h2);
    chk("full_store_dc_resp", 64'(arb2dc_response), 64'h9);
    chk("full_store_ic_resp", 64'(arb2ic_response), 64'h0);
    cyc();
    ic2arb_command = BUS_LOAD; ic2arb_addr = 'h5000;
    mem2proc_response = 4'd9;
    #1;
    chk("full_ic_cmd", 64'(proc2mem_command), 64'(BUS_NONE));
    chk("full_ic_resp", 64'(arb2ic_response), 64'h0);
    chk("store_outstanding", 64'(outstanding), 64'h8);
    cyc();
    mem2proc_tag = 4'd1;
    #1;
    chk("full_ret_dc_tag", 64'(arb2dc_tag), 64'h1);
    cyc();
    dc2arb_command = BUS_LOAD; dc2arb_addr = 'h3200;
    mem2proc_response = 4'd1;
    #1;
    chk("refill_cmd", 64'(proc2mem_command), 64'(BUS_LOAD));
    chk("refill_resp", 64'(arb2dc_response), 64'h1);
    chk("refill_outstanding", 64'(outstanding), 64'h7);
    for (int k = 1; k <= 8; k++) begin
      cyc();
      mem2proc_tag = 4'(k);
      #1;
      chk($sformatf("full_drain_tag%0d", k), 64'(arb2dc_tag), 64'(k));
    end
    cyc();
    #1;
    chk("full_drain_outstanding", 64'(outstanding), 64'h0);

    // Return of an unallocated tag.
    cyc();
    d = {$urandom, $urandom};
    mem2proc_tag = 4'd5; mem2proc_data = d;
    #1;
    chk("orphan5_pulse", 64'(orphan_tag), 64'h1);
    chk("orphan5_ic_tag", 64'(arb2ic_tag), 64'h0);
    chk("orphan5_dc_tag", 64'(arb2dc_tag), 64'h0);
    chk("orphan5_dc_data", arb2dc_data, 64'h0);
    cyc();
    #1;
    chk("orphan5_clear", 64'(orphan_tag), 64'h0);

    // Reset drops ownership of an in-flight tag.
    cyc();
    dc2arb_command = BUS_LOAD; dc2arb_addr = 'h6000;
    mem2proc_response = 4'd2;
    #1;
    cyc();
    #1;
    chk("pre_reset_outstanding", 64'(outstanding), 64'h1);
    reset = 1'b1;
    cyc();
    #1;
    reset = 1'b0;
    cyc();
    mem2proc_tag = 4'd2;
    #1;
    chk("post_reset_orphan", 64'(orphan_tag), 64'h1);
    chk("post_reset_dc_tag", 64'(arb2dc_tag), 64'h0);
    chk("post_reset_outstanding", 64'(outstanding), 64'h0);

    // Tag 7 owned by D returns while being reissued to I.
    cyc();
    dc2arb_command = BUS_LOAD; dc2arb_addr = 'h7000;
    mem2proc_response = 4'd7;
    #1;
    cyc();
    d = {$urandom, $urandom};
    ic2arb_command = BUS_LOAD; ic2arb_addr = 'h7100;
    mem2proc_response = 4'd7;
    mem2proc_tag = 4'd7; mem2proc_data = d;
    #1;
    chk("reuse_dc_tag", 64'(arb2dc_tag), 64'h7);
    chk("reuse_dc_data", arb2dc_data, d);
    chk("reuse_ic_tag", 64'(arb2ic_tag), 64'h0);
    chk("reuse_ic_resp", 64'(arb2ic_response), 64'h7);
    chk("reuse_outstanding_pre", 64'(outstanding), 64'h1);
    cyc();
    d = {$urandom, $urandom};
    mem2proc_tag = 4'd7; mem2proc_data = d;
    #1;
    chk("reuse_outstanding", 64'(outstanding), 64'h1);
    chk("reuse_ret_ic_tag", 64'(arb2ic_tag), 64'h7);
    chk("reuse_ret_ic_data", arb2ic_data, d);
    chk("reuse_ret_dc_tag", 64'(arb2dc_tag), 64'h0);
    chk("reuse_ret_orphan", 64'(orphan_tag), 64'h0);
    cyc();
    #1;
    chk("final_outstanding", 64'(outstanding), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
